pc_gen: RTL and testbench

//   Parametrised program-counter generator for the fetch stage. Holds the current PC,

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_gen_if.sv | 28 ++
 rtl/pc_redir_buf.sv | 47 ++++
 rtl/pc_gen.sv | 93 +++++++++
 tb/tb_pc_gen.sv | 106 ++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select encoding for the fetch PC generator
package pc_pkg;

  localparam int          DEF_ADDR_W       = 32;
  localparam int          DEF_INSTR_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_REDIR,
    NPC_PEND,
    NPC_EXC
  } npc_sel_t;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - pipeline/imem side signals of the PC generator
interface pc_gen_if #(
  parameter int ADDR_W = 32
);

  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              exc_valid;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus;
  logic              redir_pending;
  logic              flush;
  logic              misalign_err;

  modport master (
    output stall, redir_valid, redir_target, exc_valid, fetch_ready,
    input  fetch_valid, pc_out, pc_plus, redir_pending, flush, misalign_err
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_valid, fetch_ready,
    output fetch_valid, pc_out, pc_plus, redir_pending, flush, misalign_err
  );

endinterface

// File: rtl/pc_redir_buf.sv
// rtl/pc_redir_buf.sv - single-entry pending redirect register with target alignment
module pc_redir_buf #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_use,
  input  logic              i_capture,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_aligned,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_pend_target,
  output logic              o_misalign_err
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

  logic              r_pending;
  logic [ADDR_W-1:0] r_target;
  logic              r_misalign;

  assign o_aligned = i_target & ~LOW_MASK;

  // i_use covers both direct redirects and buffered captures; discarded ones never flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_target   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= i_use && ((i_target & LOW_MASK) != '0);
      if (i_clear) begin
        r_pending <= 1'b0;
      end else if (i_capture) begin
        r_pending <= 1'b1;
        r_target  <= o_aligned;
      end
    end
  end

  assign o_pending      = r_pending;
  assign o_pend_target  = r_target;
  assign o_misalign_err = r_misalign;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirect buffering and exception vectoring
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_fetch_valid;
  logic              r_flush;

  logic              w_adv;
  npc_sel_t          w_sel;
  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_aligned;
  logic              w_pending;
  logic [ADDR_W-1:0] w_pend_target;
  logic              w_misalign;
  logic              w_capture;
  logic              w_clear;
  logic              w_use;

  assign w_adv     = r_fetch_valid & bus.fetch_ready & ~bus.stall;
  assign w_pc_plus = r_pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    w_sel = NPC_SEQ;
    if (bus.exc_valid)
      w_sel = NPC_EXC;
    else if (w_adv && w_pending)
      w_sel = NPC_PEND;
    else if (w_adv && bus.redir_valid)
      w_sel = NPC_REDIR;

    w_pc_next = w_pc_plus;
    case (w_sel)
      NPC_EXC:   w_pc_next = EXC_VECTOR;
      NPC_PEND:  w_pc_next = w_pend_target;
      NPC_REDIR: w_pc_next = w_aligned;
      default:   w_pc_next = w_pc_plus;
    endcase
  end

  // Redirects seen while fetch is blocked are buffered; the newest one wins
  assign w_capture = ~bus.exc_valid & ~w_adv & bus.redir_valid;
  assign w_clear   = (w_sel == NPC_EXC) | (w_sel == NPC_PEND);
  assign w_use     = w_capture | (w_sel == NPC_REDIR);

  pc_redir_buf #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_redir_buf (
    .clk            (clk),
    .reset          (reset),
    .i_target       (bus.redir_target),
    .i_use          (w_use),
    .i_capture      (w_capture),
    .i_clear        (w_clear),
    .o_aligned      (w_aligned),
    .o_pending      (w_pending),
    .o_pend_target  (w_pend_target),
    .o_misalign_err (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b1;
      if (w_adv || (w_sel == NPC_EXC))
        r_pc <= w_pc_next;
      r_flush <= (w_sel != NPC_SEQ);
    end
  end

  assign bus.fetch_valid   = r_fetch_valid;
  assign bus.pc_out        = r_pc;
  assign bus.pc_plus       = w_pc_plus;
  assign bus.redir_pending = w_pending;
  assign bus.flush         = r_flush;
  assign bus.misalign_err  = w_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic fv,
                         input logic pend, input logic fl, input logic mis);
    chk({tag, ".pc"},    bus.pc_out,               pc);
    chk({tag, ".fv"},    32'(bus.fetch_valid),     32'(fv));
    chk({tag, ".pend"},  32'(bus.redir_pending),   32'(pend));
    chk({tag, ".flush"}, 32'(bus.flush),           32'(fl));
    chk({tag, ".mis"},   32'(bus.misalign_err),    32'(mis));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall        = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = '0;
    bus.exc_valid    = 1'b0;
    bus.fetch_ready  = 1'b1;

    // reset and sequential fetch
    repeat (3) @(negedge clk);
    chk_all("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk); chk_all("first", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("seq4", bus.pc_out, 32'h4);
    @(negedge clk); chk("seq8", bus.pc_out, 32'h8);
    @(negedge clk); chk("seqC", bus.pc_out, 32'hC);
    chk("plusC", bus.pc_plus, 32'h10);

    // direct redirect with advance
    bus.redir_valid = 1'b1; bus.redir_target = 32'h40;
    @(negedge clk); chk_all("r40", 32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.redir_target = 32'h100;
    @(negedge clk); chk_all("r100", 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("s104", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);

    // buffered redirects under stall, newest wins
    bus.stall = 1'b1; bus.redir_valid = 1'b1; bus.redir_target = 32'h200;
    @(negedge clk); chk_all("b200", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.redir_target = 32'h300;
    @(negedge clk); chk_all("b300", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b0; bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("p300", 32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk_all("s304", 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);

    // exception beats stall and redirect
    bus.stall = 1'b1; bus.exc_valid = 1'b1; bus.redir_valid = 1'b1; bus.redir_target = 32'h500;
    @(negedge clk); chk_all("exc", 32'h8000_0180, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.stall = 1'b0; bus.exc_valid = 1'b0; bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("exc+4", 32'h8000_0184, 1'b1, 1'b0, 1'b0, 1'b0);

    // wrap-around and misaligned target
    bus.redir_valid = 1'b1; bus.redir_target = 32'hFFFF_FFFC;
    @(negedge clk); chk_all("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("plus_wrap", bus.pc_plus, 32'h0);
    bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.redir_valid = 1'b1; bus.redir_target = 32'h103;
    @(negedge clk); chk_all("mis", 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("mis+4", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);

    // imem not ready: redirect buffered, then reset wipes it
    bus.fetch_ready = 1'b0; bus.redir_valid = 1'b1; bus.redir_target = 32'h777;
    @(negedge clk); chk_all("nr", 32'h104, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.redir_valid = 1'b0;
    @(negedge clk); chk_all("nr_hold", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk); chk_all("rst2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; bus.fetch_ready = 1'b1;
    @(negedge clk); chk_all("rst2_fv", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk_all("rst2_seq", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
